// File: rtl/router_pkg.sv
// Shared types for the router output-side blocks: beat format, drain FSM states and
// a saturating counter helper.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAY   = 2'd1,
    PAR   = 2'd2,
    ABORT = 2'd3
  } drain_state_t;

  // Bit layout {data, sop, eop, err}; data sits in the top byte.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry registered valid/ready FIFO of beats. Push and pop may happen in the same
// cycle; a push into a full buffer is accepted only when the head leaves that cycle.
module router_skid_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic [BEAT_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [BEAT_W-1:0] pop_data,
  output logic [1:0]        occ
);

  logic [BEAT_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop    = pop_ready && (count_q != 2'd0);
    do_push   = push && ((count_q != 2'd2) || do_pop);
    pop_valid = (count_q != 2'd0);
    pop_data  = mem_q[rd_ptr_q];
    occ       = count_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/router_out_drain.sv
// Drains one router output port: pops bytes, deframes header/payload/parity, tags beats
// with sop/eop/err and forwards them on a valid/ready stream through a 2-entry buffer.
module router_out_drain
  import router_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PORT_ID   = 2'd0,
  parameter int                STALL_MAX = 20
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  output logic              read_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              m_err,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers when m_valid && m_ready; while m_valid is high and
  // m_ready low the presented beat is held unchanged.

  localparam int                 STALL_W    = 5;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

  drain_state_t        state_q, state_d;
  logic                rd_pend_q;
  logic [DATA_W-1:0]   par_q;
  logic [LEN_W-1:0]    rem_q;
  logic                addr_bad_q;
  logic [STALL_W-1:0]  stall_q;
  logic [15:0]         pkt_q;
  logic [15:0]         err_q;

  logic                capture;
  logic                in_pkt;
  logic                stall_hit;
  logic                push;
  beat_t               push_beat;
  logic [1:0]          occ;
  logic [BEAT_W-1:0]   head;
  beat_t               head_beat;

  // Read issue is throttled so that every outstanding byte has a guaranteed buffer
  // slot; the abort cycle also blocks reads so nothing lands while in ABORT.
  always_comb begin
    capture   = rd_pend_q;
    in_pkt    = (state_q == PAY) || (state_q == PAR);
    stall_hit = in_pkt && !capture && (stall_q == STALL_LAST);
    read_en   = vld_out && (state_q != ABORT) && !stall_hit &&
                (({1'b0, occ} + {2'b00, rd_pend_q}) < 3'd2);
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_beat = '{data: data_out, sop: 1'b0, eop: 1'b0, err: 1'b0};
    case (state_q)
      IDLE: begin
        if (capture) begin
          push          = 1'b1;
          push_beat.sop = 1'b1;
          state_d       = (data_out[DATA_W-1:ADDR_W] != '0) ? PAY : PAR;
        end
      end
      PAY: begin
        if (capture) begin
          push    = 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? PAR : PAY;
        end else if (stall_hit) begin
          state_d = ABORT;
        end
      end
      PAR: begin
        if (capture) begin
          push          = 1'b1;
          push_beat.eop = 1'b1;
          push_beat.err = ((par_q ^ data_out) != '0) || addr_bad_q;
          state_d       = IDLE;
        end else if (stall_hit) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (occ != 2'd2) begin
          push      = 1'b1;
          push_beat = '{data: '0, sop: 1'b0, eop: 1'b1, err: 1'b1};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rd_pend_q  <= 1'b0;
      par_q      <= '0;
      rem_q      <= '0;
      addr_bad_q <= 1'b0;
      stall_q    <= '0;
      pkt_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= read_en;
      if (capture && state_q == IDLE) begin
        par_q      <= data_out;
        rem_q      <= data_out[DATA_W-1:ADDR_W];
        addr_bad_q <= (data_out[ADDR_W-1:0] != PORT_ID);
      end else if (capture && state_q == PAY) begin
        par_q <= par_q ^ data_out;
        rem_q <= rem_q - LEN_W'(1);
      end
      stall_q <= (capture || !in_pkt) ? '0 : stall_q + STALL_W'(1);
      // Packets are counted when their closing beat enters the buffer.
      if (push && push_beat.eop) begin
        pkt_q <= sat_inc(pkt_q);
        if (push_beat.err) err_q <= sat_inc(err_q);
      end
    end
  end

  router_skid_buf u_buf (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_beat),
    .pop_valid (m_valid),
    .pop_ready (m_ready),
    .pop_data  (head),
    .occ       (occ)
  );

  always_comb begin
    head_beat = beat_t'(head);
    m_data    = head_beat.data;
    m_sop     = head_beat.sop;
    m_eop     = head_beat.eop;
    m_err     = head_beat.err;
    pkt_count = pkt_q;
    err_count = err_q;
    dbg_state = state_q;
  end

endmodule
